// File: rtl/repeater_core.sv
// repeater_core: multi-port 100BASE-X repeater core with per-port
// auto-partition and optional jabber lockout.
// Optional feature: define REPEATER_JABBER_EN to build jabber counters and lockout;
// without it the jabber output is tied to 0 and JABBER_LEN is unused.
module repeater_core #(
  parameter int unsigned PORT_COUNT      = 4,
  parameter int unsigned COLLISION_LIMIT = 31,
  parameter int unsigned UNPARTITION_LEN = 128,
  parameter int unsigned JABBER_LEN      = 6250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic [PORT_COUNT-1:0]   rx_dv,
  input  logic [PORT_COUNT-1:0]   rx_er,
  input  logic [4*PORT_COUNT-1:0] rxd,
  output logic [PORT_COUNT-1:0]   tx_en,
  output logic [PORT_COUNT-1:0]   tx_er,
  output logic [4*PORT_COUNT-1:0] txd,
  output logic                    jam,
  output logic                    activity,
  output logic [PORT_COUNT-1:0]   partitioned,
  output logic [PORT_COUNT-1:0]   jabber
);

  localparam int unsigned CW = $clog2(COLLISION_LIMIT + 1);
  localparam int unsigned UW = $clog2(UNPARTITION_LEN + 1);
  localparam int unsigned SW = $clog2(PORT_COUNT);

  typedef enum logic {StConnected, StPartitioned} part_state_e;

  // Eligibility and activity classification
  logic [PORT_COUNT-1:0] lock_q;
  logic [PORT_COUNT-1:0] eligible;
  logic [PORT_COUNT-1:0] active;
  logic                  any_active;
  logic                  multi_active;

  assign eligible     = ~lock_q & ~partitioned;
  assign active       = rx_dv & eligible;
  assign any_active   = |active;
  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign multi_active = |(active & (active - PORT_COUNT'(1)));

  // Output datapath state
  logic [PORT_COUNT-1:0]   tx_en_q, tx_en_d;
  logic [PORT_COUNT-1:0]   tx_er_q, tx_er_d;
  logic [4*PORT_COUNT-1:0] txd_q, txd_d;
  logic                    jam_q, jam_d;
  logic                    activity_q, activity_d;
  logic [SW-1:0]           src;

  // Partition state per port
  part_state_e [PORT_COUNT-1:0]         state_q, state_d;
  logic        [PORT_COUNT-1:0][CW-1:0] ccount_q, ccount_d;
  logic        [PORT_COUNT-1:0][UW-1:0] ulen_q, ulen_d;
  logic        [PORT_COUNT-1:0]         saw_col_q, saw_col_d;
  logic        [PORT_COUNT-1:0]         ureach_q, ureach_d;
  logic        [PORT_COUNT-1:0]         dv_prev_q;

  // Next outputs: idle, repeat the single active port, or jam
  always_comb begin
    tx_en_d    = '0;
    tx_er_d    = '0;
    txd_d      = '0;
    jam_d      = 1'b0;
    activity_d = 1'b0;
    src        = '0;
    for (int unsigned i = 0; i < PORT_COUNT; i++) begin
      if (active[i]) src = SW'(i);
    end
    if (multi_active) begin
      tx_en_d    = '1;
      txd_d      = {PORT_COUNT{4'h5}};
      jam_d      = 1'b1;
      activity_d = 1'b1;
    end else if (any_active) begin
      activity_d = 1'b1;
      for (int unsigned i = 0; i < PORT_COUNT; i++) begin
        if (!active[i]) begin
          tx_en_d[i]       = 1'b1;
          tx_er_d[i]       = rx_er[src];
          txd_d[4*i +: 4]  = rxd[4*src +: 4];
        end
      end
    end
  end

  // Partition FSM next state, collision counting and reconnect run length
  always_comb begin
    logic ev_end;
    logic others_dv;
    state_d   = state_q;
    ccount_d  = ccount_q;
    ulen_d    = ulen_q;
    saw_col_d = saw_col_q;
    ureach_d  = ureach_q;
    ev_end    = 1'b0;
    others_dv = 1'b0;
    for (int unsigned i = 0; i < PORT_COUNT; i++) begin
      ev_end    = dv_prev_q[i] & ~rx_dv[i];
      others_dv = |(rx_dv & ~(PORT_COUNT'(1) << i));
      if (active[i] && multi_active) saw_col_d[i] = 1'b1;
      if (ev_end) saw_col_d[i] = 1'b0;
      unique case (state_q[i])
        StConnected: begin
          ulen_d[i]   = '0;
          ureach_d[i] = 1'b0;
          if (ev_end) begin
            if (saw_col_q[i]) begin
              if (ccount_q[i] >= CW'(COLLISION_LIMIT - 1)) begin
                state_d[i]  = StPartitioned;
                ccount_d[i] = '0;
              end else begin
                ccount_d[i] = ccount_q[i] + CW'(1);
              end
            end else begin
              ccount_d[i] = '0;
            end
          end
        end
        StPartitioned: begin
          if (rx_dv[i] && !others_dv) begin
            if (ulen_q[i] != UW'(UNPARTITION_LEN)) ulen_d[i] = ulen_q[i] + UW'(1);
            if (ulen_d[i] == UW'(UNPARTITION_LEN)) ureach_d[i] = 1'b1;
          end else begin
            ulen_d[i] = '0;
          end
          // Reconnect is deferred to the end of the qualifying carrier event.
          if (ev_end && ureach_q[i]) begin
            state_d[i]  = StConnected;
            ureach_d[i] = 1'b0;
            ulen_d[i]   = '0;
            ccount_d[i] = '0;
          end
        end
        default: state_d[i] = StConnected;
      endcase
    end
  end

  // Core state registers, advanced only on ce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en_q    <= '0;
      tx_er_q    <= '0;
      txd_q      <= '0;
      jam_q      <= 1'b0;
      activity_q <= 1'b0;
      for (int unsigned i = 0; i < PORT_COUNT; i++) state_q[i] <= StConnected;
      ccount_q   <= '0;
      ulen_q     <= '0;
      saw_col_q  <= '0;
      ureach_q   <= '0;
      dv_prev_q  <= '0;
    end else if (ce) begin
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
      txd_q      <= txd_d;
      jam_q      <= jam_d;
      activity_q <= activity_d;
      state_q    <= state_d;
      ccount_q   <= ccount_d;
      ulen_q     <= ulen_d;
      saw_col_q  <= saw_col_d;
      ureach_q   <= ureach_d;
      dv_prev_q  <= rx_dv;
    end
  end

`ifdef REPEATER_JABBER_EN
  localparam int unsigned JW = $clog2(JABBER_LEN + 1);

  logic [PORT_COUNT-1:0][JW-1:0] jcnt_q, jcnt_d;
  logic [PORT_COUNT-1:0]         lock_d;

  // Jabber run counters; lock holds until the port drops rx_dv
  always_comb begin
    jcnt_d = jcnt_q;
    lock_d = lock_q;
    for (int unsigned i = 0; i < PORT_COUNT; i++) begin
      if (lock_q[i]) begin
        jcnt_d[i] = '0;
        if (!rx_dv[i]) lock_d[i] = 1'b0;
      end else if (active[i]) begin
        if (jcnt_q[i] != JW'(JABBER_LEN)) jcnt_d[i] = jcnt_q[i] + JW'(1);
        if (jcnt_d[i] == JW'(JABBER_LEN)) lock_d[i] = 1'b1;
      end else begin
        jcnt_d[i] = '0;
      end
    end
  end

  // Jabber state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jcnt_q <= '0;
      lock_q <= '0;
    end else if (ce) begin
      jcnt_q <= jcnt_d;
      lock_q <= lock_d;
    end
  end
`else
  logic [31:0] unused_jabber_len;
  assign unused_jabber_len = JABBER_LEN;
  assign lock_q            = '0;
`endif

  // Partition status decoded from the per-port FSM state
  always_comb begin
    partitioned = '0;
    for (int unsigned i = 0; i < PORT_COUNT; i++) begin
      partitioned[i] = (state_q[i] == StPartitioned);
    end
  end

  assign tx_en    = tx_en_q;
  assign tx_er    = tx_er_q;
  assign txd      = txd_q;
  assign jam      = jam_q;
  assign activity = activity_q;
  assign jabber   = lock_q;

endmodule

// File: tb/tb_repeater_core.sv
// tb_repeater_core: directed, table-driven bench for repeater_core (4 ports,
// COLLISION_LIMIT=3, UNPARTITION_LEN=8, JABBER_LEN=16).
module tb_repeater_core;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [3:0]  rx_dv;
  logic [3:0]  rx_er;
  logic [15:0] rxd;
  logic [3:0]  tx_en;
  logic [3:0]  tx_er;
  logic [15:0] txd;
  logic        jam;
  logic        activity;
  logic [3:0]  partitioned;
  logic [3:0]  jabber;

  int checks;
  int failures;

  repeater_core #(
    .PORT_COUNT      (4),
    .COLLISION_LIMIT (3),
    .UNPARTITION_LEN (8),
    .JABBER_LEN      (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .rx_dv       (rx_dv),
    .rx_er       (rx_er),
    .rxd         (rxd),
    .tx_en       (tx_en),
    .tx_er       (tx_er),
    .txd         (txd),
    .jam         (jam),
    .activity    (activity),
    .partitioned (partitioned),
    .jabber      (jabber)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  typedef struct {
    logic [3:0]  dv;
    logic [3:0]  er;
    logic [15:0] d;
    logic [3:0]  en;
    logic [3:0]  ter;
    logic [15:0] td;
    logic        j;
    logic        a;
  } vec_t;

  vec_t vecs [11];

  // One ce period: inputs and ce set at a falling edge, outputs left stable for sampling.
  task automatic tick(input logic [3:0] dv, input logic [3:0] er, input logic [15:0] d);
    @(negedge clk);
    rx_dv = dv;
    rx_er = er;
    rxd   = d;
    ce    = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] en, input logic [3:0] ter,
                       input logic [15:0] td, input logic j, input logic a,
                       input logic [3:0] p, input logic [3:0] jb);
    checks++;
    if ({tx_en, tx_er, txd, jam, activity, partitioned, jabber} !== {en, ter, td, j, a, p, jb}) begin
      failures++;
      $display("FAIL %s: got en=%b er=%b txd=%h jam=%b act=%b part=%b jab=%b; want en=%b er=%b txd=%h jam=%b act=%b part=%b jab=%b",
               name, tx_en, tx_er, txd, jam, activity, partitioned, jabber,
               en, ter, td, j, a, p, jb);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //            dv     er     rxd       tx_en  tx_er  txd       jam   act
    vecs[0]  = '{4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{4'h2, 4'h0, 16'h00A0, 4'hD, 4'h0, 16'hAA0A, 1'b0, 1'b1};
    vecs[2]  = '{4'h2, 4'h2, 16'h00C0, 4'hD, 4'hD, 16'hCC0C, 1'b0, 1'b1};
    vecs[3]  = '{4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{4'h5, 4'h0, 16'h0307, 4'hF, 4'h0, 16'h5555, 1'b1, 1'b1};
    vecs[5]  = '{4'h5, 4'h1, 16'h0307, 4'hF, 4'h0, 16'h5555, 1'b1, 1'b1};
    vecs[6]  = '{4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{4'h8, 4'h0, 16'h9000, 4'h7, 4'h0, 16'h0999, 1'b0, 1'b1};
    vecs[8]  = '{4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{4'h1, 4'h1, 16'h0003, 4'hE, 4'hE, 16'h3330, 1'b0, 1'b1};
    vecs[10] = '{4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0};

    rst_n = 1'b0;
    ce    = 1'b0;
    rx_dv = '0;
    rx_er = '0;
    rxd   = '0;
    repeat (3) @(negedge clk);
    check("reset_state", 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      tick(vecs[i].dv, vecs[i].er, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].en, vecs[i].ter, vecs[i].td,
            vecs[i].j, vecs[i].a, 4'h0, 4'h0);
    end

    // Input changes without ce must not move the outputs.
    @(negedge clk);
    rx_dv = 4'h2;
    rxd   = 16'h00A0;
    repeat (4) @(negedge clk);
    check("ce_gate", 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 4'h0);

    // Ports 0 and 3 collide in three consecutive carrier events.
    for (int e = 1; e <= 3; e++) begin
      tick(4'h9, 4'h0, 16'h1001);
      check("col_jam", 4'hF, 4'h0, 16'h5555, 1'b1, 1'b1, 4'h0, 4'h0);
      tick(4'h9, 4'h0, 16'h1001);
      tick(4'h0, 4'h0, 16'h0000);
      if (e < 3) check("col_not_yet", 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 4'h0);
      else       check("col_partition", 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h9, 4'h0);
    end

    // Partitioned port 3 is not repeated.
    tick(4'h8, 4'h0, 16'h9000);
    check("part_no_repeat", 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h9, 4'h0);
    tick(4'h0, 4'h0, 16'h0000);

    // A 7-nibble solo burst is one short of reconnecting.
    for (int k = 0; k < 7; k++) tick(4'h8, 4'h0, 16'h9000);
    tick(4'h0, 4'h0, 16'h0000);
    check("short_burst_stays", 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h9, 4'h0);

    // A 10-nibble solo burst reconnects at event end.
    for (int k = 0; k < 10; k++) tick(4'h8, 4'h0, 16'h9000);
    check("long_burst_held", 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h9, 4'h0);
    tick(4'h0, 4'h0, 16'h0000);
    check("reconnect", 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h1, 4'h0);
    tick(4'h8, 4'h0, 16'hB000);
    check("reconnect_repeat", 4'h7, 4'h0, 16'h0BBB, 1'b0, 1'b1, 4'h1, 4'h0);
    tick(4'h0, 4'h0, 16'h0000);

    // Port 2 holds carrier for 40 ce.
    for (int k = 1; k <= 40; k++) begin
      tick(4'h4, 4'h0, 16'h0E00);
`ifdef REPEATER_JABBER_EN
      if (k <= 16)
        check("jabber_run", 4'hB, 4'h0, 16'hE0EE, 1'b0, 1'b1, 4'h1, (k == 16) ? 4'h4 : 4'h0);
      else
        check("jabber_lock", 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h1, 4'h4);
`else
      check("long_run", 4'hB, 4'h0, 16'hE0EE, 1'b0, 1'b1, 4'h1, 4'h0);
`endif
    end
    tick(4'h0, 4'h0, 16'h0000);
    check("jabber_release", 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h1, 4'h0);
    tick(4'h4, 4'h0, 16'h0E00);
    check("after_release", 4'hB, 4'h0, 16'hE0EE, 1'b0, 1'b1, 4'h1, 4'h0);
    tick(4'h0, 4'h0, 16'h0000);

    // Reset mid-frame while port 0 is partitioned.
    tick(4'h2, 4'h0, 16'h00A0);
    check("pre_reset_frame", 4'hD, 4'h0, 16'hAA0A, 1'b0, 1'b1, 4'h1, 4'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_async", 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick(4'h0, 4'h0, 16'h0000);
    check("post_reset_idle", 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    tick(4'h1, 4'h0, 16'h0002);
    check("post_reset_port0", 4'hE, 4'h0, 16'h2220, 1'b0, 1'b1, 4'h0, 4'h0);
    tick(4'h0, 4'h0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
